ir_nec_decoder: RTL and testbench
=================================

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency used to derive the 1 us tick.
REQ-002 Parameter HOLD_US, default 110_000, key-held timeout after the last valid frame or repeat code.
REQ-003 clk  input  1  system clock; all logic on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ir_in  input  1  raw IR receiver output, asynchronous, active-low (0 = carrier mark).
REQ-006 address  output  8  address byte of the last valid frame.
REQ-007 command  output  8  command byte of the last valid frame.
REQ-008 data_valid  output  1  one-cycle pulse when a full valid frame has decoded.
REQ-009 repeat_valid  output  1  one-cycle pulse on a valid repeat code while key_held=1.
REQ-010 error  output  1  one-cycle pulse on any malformed frame.
REQ-011 key_held  output  1  level; high while a key is held; drives the downstream timer's start_timer.

Function
REQ-012 ir_in SHALL pass through a 2-flop synchronizer; all decoding SHALL use the synchronized, inverted signal (mark=1).
REQ-013 A prescaler SHALL produce a one-cycle tick every CLK_HZ/1_000_000 clocks (50 at default).
REQ-014 A 16-bit duration counter SHALL count ticks since the last mark/space edge, clear to 0 on each edge, and saturate at 65535.
REQ-015 FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, TRAIL_MARK, REP_MARK.
REQ-016 IDLE -> LEAD_MARK on mark rising edge; no other transition out of IDLE.
REQ-017 LEAD_MARK at mark fall: 8000-10000 us -> LEAD_SPACE; else error, IDLE.
REQ-018 LEAD_SPACE at mark rise: 4000-5000 us -> BIT_MARK with bit index 0; 2000-2500 us -> REP_MARK; else error, IDLE.
REQ-019 BIT_MARK at mark fall: 400-700 us -> BIT_SPACE; else error, IDLE.
REQ-020 BIT_SPACE at mark rise: 400-800 us shifts in 0, 1400-2000 us shifts in 1, LSB first into a 32-bit shift register; else error, IDLE.
REQ-021 After bit 31 is shifted, next state SHALL be TRAIL_MARK; otherwise BIT_MARK with index+1.
REQ-022 TRAIL_MARK at mark fall: 400-700 us and byte1 == ~byte0 and byte3 == ~byte2 -> address<=byte0, command<=byte2, data_valid pulse, IDLE; else error, IDLE.
REQ-023 REP_MARK at mark fall: 400-700 us and key_held=1 -> repeat_valid pulse, IDLE; 400-700 us with key_held=0 -> IDLE, no pulses; else error, IDLE.
REQ-024 In any non-IDLE state, a duration exceeding its window's upper bound without an edge SHALL cause error and IDLE immediately (no waiting for the edge).
REQ-025 Pulses SHALL be asserted in the cycle after the qualifying edge is detected; data_valid, repeat_valid, error mutually exclusive.
REQ-026 address/command SHALL update only on data_valid and otherwise hold.
REQ-027 key_held SHALL rise the cycle data_valid pulses; a hold counter (in us ticks) SHALL reload on data_valid or repeat_valid and key_held SHALL fall when it reaches HOLD_US.
REQ-028 error SHALL NOT clear key_held; only timeout or reset does.
REQ-029 Window bounds are inclusive; a value exactly at a bound is accepted.

Reset
REQ-030 On reset: FSM=IDLE, synchronizer flops=1 (idle, no mark), prescaler, duration, hold counter, shift register=0; address=0, command=0, data_valid=0, repeat_valid=0, error=0, key_held=0.
REQ-031 Reset mid-frame SHALL abort decoding with no pulse; decoding restarts only at the next mark rising edge after reset deasserts.

Verification
REQ-032 Valid NEC frame addr 0x00, cmd 0x45 (9ms/4.5ms/bits/562us trailer) -> one data_valid, address=0x00, command=0x45, key_held=1.
REQ-033 Same frame then repeat codes every 108 ms x3 -> three repeat_valid pulses; key_held high until 110 ms after last repeat, then 0.
REQ-034 Frame with command inverse byte corrupted (0x45, 0xBB) -> error pulse, no data_valid, address/command unchanged.
REQ-035 Leader mark 6 ms -> error at mark fall, IDLE; space stuck >2000 us in BIT_SPACE -> error at 2001 us without an edge.
REQ-036 Repeat code with key_held=0 -> no pulses; reset asserted at bit 15 of a frame -> all outputs 0, next full frame decodes correctly.
REQ-037 Bit space exactly 400 us and 2000 us -> accepted as 0 and 1 respectively.

Source files
------------

// File: rtl/ir_nec_decoder.sv
// rtl/ir_nec_decoder.sv - NEC infrared remote frame, repeat-code and key-hold decoder
module ir_nec_decoder #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int HOLD_US = 110_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ir_in,
    output logic [7:0] address,
    output logic [7:0] command,
    output logic       data_valid,
    output logic       repeat_valid,
    output logic       error,
    output logic       key_held
);

    // Clocks per microsecond; never below one so slow clocks still tick.
    localparam int TICK_DIV = (CLK_HZ / 1_000_000 > 1) ? (CLK_HZ / 1_000_000) : 1;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW       = (HOLD_US > 1) ? $clog2(HOLD_US + 1) : 1;

    // Timing windows in microseconds, bounds inclusive.
    localparam logic [16:0] LEAD_MARK_LO  = 17'd8000;
    localparam logic [16:0] LEAD_MARK_HI  = 17'd10000;
    localparam logic [16:0] LEAD_SPACE_LO = 17'd4000;
    localparam logic [16:0] LEAD_SPACE_HI = 17'd5000;
    localparam logic [16:0] REP_SPACE_LO  = 17'd2000;
    localparam logic [16:0] REP_SPACE_HI  = 17'd2500;
    localparam logic [16:0] BIT_MARK_LO   = 17'd400;
    localparam logic [16:0] BIT_MARK_HI   = 17'd700;
    localparam logic [16:0] ZERO_SPACE_LO = 17'd400;
    localparam logic [16:0] ZERO_SPACE_HI = 17'd800;
    localparam logic [16:0] ONE_SPACE_LO  = 17'd1400;
    localparam logic [16:0] ONE_SPACE_HI  = 17'd2000;
    localparam logic [16:0] NO_LIMIT      = 17'h1FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_TRAIL_MARK,
        S_REP_MARK
    } state_t;

    state_t          state_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            mark_q;
    logic [PW-1:0]   presc_q;
    logic [15:0]     dur_q;
    logic [HW-1:0]   hold_q;
    logic [31:0]     shift_q;
    logic [4:0]      bit_idx_q;
    logic [7:0]      address_q;
    logic [7:0]      command_q;
    logic            data_valid_q;
    logic            repeat_valid_q;
    logic            error_q;
    logic            key_held_q;

    logic            mark_now;
    logic            rise;
    logic            fall;
    logic            tick;
    logic [16:0]     meas;
    logic [16:0]     upper;
    logic            timeout;

    // Synchronized, inverted receiver output: 1 while the carrier mark is present.
    assign mark_now = ~sync2_q;
    assign rise     = mark_now & ~mark_q;
    assign fall     = ~mark_now & mark_q;
    assign tick     = (presc_q == PW'(TICK_DIV - 1));
    // The tick landing in the edge cycle belongs to the interval that just ended.
    assign meas     = {1'b0, dur_q} + {16'd0, tick};
    assign timeout  = (state_q != S_IDLE) && (meas > upper);

    function automatic logic in_win(input logic [16:0] v, input logic [16:0] lo,
                                    input logic [16:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // Two-flop synchronizer plus the previous mark level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            mark_q  <= 1'b0;
        end else begin
            sync1_q <= ir_in;
            sync2_q <= sync1_q;
            mark_q  <= mark_now;
        end
    end

    // Free-running prescaler producing the 1 us tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PW'(1);
        end
    end

    // Microseconds since the last mark/space edge, saturating.
    always_ff @(posedge clk) begin
        if (reset) begin
            dur_q <= 16'd0;
        end else if (rise || fall) begin
            dur_q <= 16'd0;
        end else if (tick && (dur_q != 16'hFFFF)) begin
            dur_q <= dur_q + 16'd1;
        end
    end

    // Longest legal duration of the current phase; exceeding it aborts at once.
    always_comb begin
        upper = NO_LIMIT;
        case (state_q)
            S_LEAD_MARK:  upper = LEAD_MARK_HI;
            S_LEAD_SPACE: upper = LEAD_SPACE_HI;
            S_BIT_MARK:   upper = BIT_MARK_HI;
            S_BIT_SPACE:  upper = ONE_SPACE_HI;
            S_TRAIL_MARK: upper = BIT_MARK_HI;
            S_REP_MARK:   upper = BIT_MARK_HI;
            default:      upper = NO_LIMIT;
        endcase
    end

    // Frame FSM with registered pulses, decoded bytes and key-hold timer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            shift_q        <= 32'd0;
            bit_idx_q      <= 5'd0;
            hold_q         <= '0;
            address_q      <= 8'd0;
            command_q      <= 8'd0;
            data_valid_q   <= 1'b0;
            repeat_valid_q <= 1'b0;
            error_q        <= 1'b0;
            key_held_q     <= 1'b0;
        end else begin
            data_valid_q   <= 1'b0;
            repeat_valid_q <= 1'b0;
            error_q        <= 1'b0;

            // Hold timer; a reload from the FSM below takes precedence.
            if (key_held_q && tick) begin
                if (hold_q == HW'(HOLD_US - 1)) begin
                    key_held_q <= 1'b0;
                    hold_q     <= '0;
                end else begin
                    hold_q <= hold_q + HW'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_q <= S_LEAD_MARK;
                    end
                end

                S_LEAD_MARK: begin
                    if (fall) begin
                        if (in_win(meas, LEAD_MARK_LO, LEAD_MARK_HI)) begin
                            state_q <= S_LEAD_SPACE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_LEAD_SPACE: begin
                    if (rise) begin
                        if (in_win(meas, LEAD_SPACE_LO, LEAD_SPACE_HI)) begin
                            bit_idx_q <= 5'd0;
                            state_q   <= S_BIT_MARK;
                        end else if (in_win(meas, REP_SPACE_LO, REP_SPACE_HI)) begin
                            state_q <= S_REP_MARK;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_BIT_MARK: begin
                    if (fall) begin
                        if (in_win(meas, BIT_MARK_LO, BIT_MARK_HI)) begin
                            state_q <= S_BIT_SPACE;
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_BIT_SPACE: begin
                    if (rise) begin
                        if (in_win(meas, ZERO_SPACE_LO, ZERO_SPACE_HI) ||
                            in_win(meas, ONE_SPACE_LO, ONE_SPACE_HI)) begin
                            // LSB first: the newest bit enters at the top.
                            shift_q <= {in_win(meas, ONE_SPACE_LO, ONE_SPACE_HI),
                                        shift_q[31:1]};
                            if (bit_idx_q == 5'd31) begin
                                state_q <= S_TRAIL_MARK;
                            end else begin
                                bit_idx_q <= bit_idx_q + 5'd1;
                                state_q   <= S_BIT_MARK;
                            end
                        end else begin
                            error_q <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_TRAIL_MARK: begin
                    if (fall) begin
                        if (in_win(meas, BIT_MARK_LO, BIT_MARK_HI) &&
                            (shift_q[15:8] == ~shift_q[7:0]) &&
                            (shift_q[31:24] == ~shift_q[23:16])) begin
                            address_q    <= shift_q[7:0];
                            command_q    <= shift_q[23:16];
                            data_valid_q <= 1'b1;
                            key_held_q   <= 1'b1;
                            hold_q       <= '0;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                S_REP_MARK: begin
                    if (fall) begin
                        if (in_win(meas, BIT_MARK_LO, BIT_MARK_HI)) begin
                            // A repeat without a held key is silently ignored.
                            if (key_held_q) begin
                                repeat_valid_q <= 1'b1;
                                hold_q         <= '0;
                            end
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end else if (timeout) begin
                        error_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign address      = address_q;
    assign command      = command_q;
    assign data_valid   = data_valid_q;
    assign repeat_valid = repeat_valid_q;
    assign error        = error_q;
    assign key_held     = key_held_q;

endmodule

// File: tb/tb_ir_nec_decoder.sv
// tb/tb_ir_nec_decoder.sv - scoreboard bench for ir_nec_decoder
`timescale 1ns/1ps
module tb_ir_nec_decoder;

    localparam int HOLD = 20000;
    localparam int PIPE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       ir_in;
    logic [7:0] address;
    logic [7:0] command;
    logic       data_valid;
    logic       repeat_valid;
    logic       error;
    logic       key_held;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] cmd;
    } exp_t;

    exp_t sb[$];
    int   n_tests      = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   last_err_cyc = -1;
    int   last_rep_cyc = -1;
    int   p;

    ir_nec_decoder #(
        .CLK_HZ  (1_000_000),
        .HOLD_US (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ir_in        (ir_in),
        .address      (address),
        .command      (command),
        .data_valid   (data_valid),
        .repeat_valid (repeat_valid),
        .error        (error),
        .key_held     (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_pulse(input int kind, input logic [7:0] a, input logic [7:0] c);
        exp_t e;
        e.kind = kind;
        e.addr = a;
        e.cmd  = c;
        sb.push_back(e);
    endtask

    // Pulse monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        int   kind;
        exp_t e;
        if (!reset && (data_valid || repeat_valid || error)) begin
            check_eq("pulse_onehot", 32'(data_valid) + 32'(repeat_valid) + 32'(error), 1);
            kind = data_valid ? 1 : (repeat_valid ? 2 : 3);
            if (kind == 2) last_rep_cyc = cyc;
            if (kind == 3) last_err_cyc = cyc;
            if (sb.size() == 0) begin
                check_eq("unexpected_pulse", kind, 0);
            end else begin
                e = sb.pop_front();
                check_eq("pulse_kind", kind, e.kind);
                if (kind == 1) begin
                    check_eq("pulse_address", address, e.addr);
                    check_eq("pulse_command", command, e.cmd);
                end
            end
        end
    end

    task automatic hold_lvl(input logic v, input int n);
        ir_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [31:0] d, input int nbits, input int mk,
                             input int zsp, input int osp);
        hold_lvl(1'b0, 9000);
        hold_lvl(1'b1, 4500);
        for (int i = 0; i < nbits; i++) begin
            hold_lvl(1'b0, mk);
            hold_lvl(1'b1, d[i] ? osp : zsp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input int mk, input int zsp, input int osp);
        send_bits({b3, b2, b1, b0}, 32, mk, zsp, osp);
        hold_lvl(1'b0, mk);
        hold_lvl(1'b1, 20);
    endtask

    task automatic send_repeat(input int gap);
        hold_lvl(1'b1, gap);
        hold_lvl(1'b0, 9000);
        hold_lvl(1'b1, 2250);
        hold_lvl(1'b0, 562);
        hold_lvl(1'b1, 20);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_address"}, address, 0);
        check_eq({tag, "_command"}, command, 0);
        check_eq({tag, "_data_valid"}, data_valid, 0);
        check_eq({tag, "_repeat_valid"}, repeat_valid, 0);
        check_eq({tag, "_error"}, error, 0);
        check_eq({tag, "_key_held"}, key_held, 0);
    endtask

    initial begin : watchdog
        #6_000_000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1;
        ir_in = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        hold_lvl(1'b1, 100);

        // Frame cut short by reset during bit 15: no pulse, all outputs clear.
        send_bits(32'hBA45FF00, 15, 562, 562, 1687);
        hold_lvl(1'b0, 200);
        reset = 1'b1;
        ir_in = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_all_zero("midreset");
        reset = 1'b0;
        hold_lvl(1'b1, 1000);

        // Valid frame 0x00/0x45 with boundary bit spaces 400 us and 2000 us.
        expect_pulse(1, 8'h00, 8'h45);
        send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 562, 400, 2000);
        check_eq("frame1_address", address, 8'h00);
        check_eq("frame1_command", command, 8'h45);
        check_eq("frame1_key_held", key_held, 1);

        // Three repeat codes while held.
        for (int r = 0; r < 3; r++) begin
            expect_pulse(2, 8'h00, 8'h00);
            send_repeat(3000);
        end
        check_eq("repeat_key_held", key_held, 1);

        // 6 ms leader: error at the mark fall, key stays held.
        hold_lvl(1'b1, 1000);
        expect_pulse(3, 8'h00, 8'h00);
        hold_lvl(1'b0, 6000);
        p = cyc;
        hold_lvl(1'b1, 10);
        check_eq("short_lead_err_cyc", last_err_cyc, p + PIPE);
        check_eq("key_held_after_err", key_held, 1);

        // Hold expires exactly HOLD us after the last repeat.
        while (cyc < last_rep_cyc + HOLD - 1) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("hold_before_expiry", key_held, 1);
        @(negedge clk);
        check_eq("hold_after_expiry", key_held, 0);
        @(posedge clk);
        #1;

        // Repeat code without a held key: no pulses at all.
        send_repeat(500);
        check_eq("norep_key_held", key_held, 0);

        // Command inverse corrupted: error, decoded bytes unchanged.
        expect_pulse(3, 8'h00, 8'h00);
        send_frame(8'h12, 8'hED, 8'h45, 8'hBB, 562, 562, 1687);
        check_eq("corrupt_address", address, 8'h00);
        check_eq("corrupt_command", command, 8'h45);

        // Bit space stuck high: error 2001 us after the space began.
        expect_pulse(3, 8'h00, 8'h00);
        hold_lvl(1'b1, 500);
        hold_lvl(1'b0, 9000);
        hold_lvl(1'b1, 4500);
        hold_lvl(1'b0, 562);
        p = cyc;
        hold_lvl(1'b1, 2100);
        check_eq("stuck_space_err_cyc", last_err_cyc, p + 2001 + PIPE);

        hold_lvl(1'b1, 20);
        check_eq("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
